// File: rtl/run_ctrl_pkg.sv
// Shared types and default window constants for the run controller.
// No logic here; latency and backpressure are defined by the modules that import it.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } run_state_e;

    localparam int DEF_AW         = 8;
    localparam int DEF_LOAD_BASE  = 0;
    localparam int DEF_LOAD_LEN   = 64;
    localparam int DEF_DRAIN_BASE = 64;
    localparam int DEF_DRAIN_LEN  = 32;
    localparam int DEF_CW         = 20;
    localparam int DEF_TIMEOUT    = 1000000;

    // Bits needed to hold a window length itself (so len-1 and len both fit).
    function automatic int ptr_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Load stream, drain stream and data-memory port of the run controller.
// Valid/ready on both streams; master is the controller, slave is the environment.
interface run_ctrl_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdat;
    logic [7:0]    mem_rdat;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdat,
        output in_ready, out_valid, out_data, mem_sel, mem_wr_en, mem_addr, mem_wdat
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdat,
        input  in_ready, out_valid, out_data, mem_sel, mem_wr_en, mem_addr, mem_wdat
    );
endinterface

// File: rtl/run_ctrl_addr_walker.sv
// Window pointer shared by LOAD and DRAIN: base+ptr address, step per handshake, last flag.
// Address and last are combinational from the pointer; steps only when told, so stalls hold it.
module run_ctrl_addr_walker
    import run_ctrl_pkg::*;
#(
    parameter  int AW  = 8,
    parameter  int LEN = 64,
    localparam int PW  = ptr_width(LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_step,
    input  logic [AW-1:0] i_base,
    input  logic [PW-1:0] i_len,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);
    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_step) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Address wraps naturally modulo 2**AW.
    assign o_addr = i_base + AW'(r_ptr);
    assign o_last = (r_ptr == (i_len - PW'(1)));

endmodule

// File: rtl/run_ctrl.sv
// Run controller: preload data memory, release the core until halt/timeout, drain a result window.
// Streams are combinational valid/ready (zero-latency write/read); stalls hold pointer and address.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int LOAD_BASE  = DEF_LOAD_BASE,
    parameter int LOAD_LEN   = DEF_LOAD_LEN,
    parameter int DRAIN_BASE = DEF_DRAIN_BASE,
    parameter int DRAIN_LEN  = DEF_DRAIN_LEN,
    parameter int CW         = DEF_CW,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    run_ctrl_if.master    bus,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          timed_out,
    output logic          finished,
    output logic [CW-1:0] cycle_count
);
    localparam int            MAX_LEN = (LOAD_LEN > DRAIN_LEN) ? LOAD_LEN : DRAIN_LEN;
    localparam int            PW      = ptr_width(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    run_state_e    r_state;
    run_state_e    w_state_nxt;
    logic [CW-1:0] r_cycle_count;
    logic          r_timed_out;
    logic          w_clr;
    logic          w_step;
    logic          w_last;
    logic          w_to_hit;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_addr;
    logic [PW-1:0] w_len;

    run_ctrl_addr_walker #(
        .AW  (AW),
        .LEN (MAX_LEN)
    ) u_walker (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_step (w_step),
        .i_base (w_base),
        .i_len  (w_len),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    assign w_to_hit = (r_cycle_count == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stream handshakes are masked by reset so an abort never commits a write or a beat.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr          = 1'b0;
        w_step         = 1'b0;
        w_base         = AW'(LOAD_BASE);
        w_len          = PW'(LOAD_LEN);
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = 8'h00;
        bus.mem_sel    = 1'b1;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdat   = 8'h00;
        core_reset     = 1'b1;
        busy           = (r_state != S_IDLE);
        finished       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = (LOAD_LEN == 0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                bus.in_ready  = !reset;
                bus.mem_addr  = w_addr;
                bus.mem_wdat  = bus.in_data;
                bus.mem_wr_en = bus.in_valid && !reset;
                w_step        = bus.in_valid;
                if (bus.in_valid && w_last) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                core_reset  = 1'b0;
                bus.mem_sel = 1'b0;
                if (core_done || w_to_hit) begin
                    w_state_nxt = (DRAIN_LEN == 0) ? S_FINISH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_base        = AW'(DRAIN_BASE);
                w_len         = PW'(DRAIN_LEN);
                bus.out_valid = !reset;
                bus.out_data  = bus.mem_rdat;
                bus.mem_addr  = w_addr;
                w_step        = bus.out_ready;
                if (bus.out_ready && w_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                finished    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A halt seen on the timeout cycle counts as a normal finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (w_to_hit && !core_done) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign timed_out   = r_timed_out;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run controller directly upstream of the processor core. Holds the core in reset and preloads a byte image into data memory through a valid/ready input stream.
- Then releases the core and counts cycles until the core raises its halt indication (or a timeout fires).
- Finally streams a result window of data memory out through a valid/ready output stream.
- Owns the data-memory port whenever the core is not running.

Parameters:
AW, 8, data-memory address width
LOAD_BASE, 0, first memory address written during load
LOAD_LEN, 64, number of bytes loaded (0 = skip load)
DRAIN_BASE, 64, first memory address read during drain
DRAIN_LEN, 32, number of bytes drained (0 = skip drain)
CW, 20, cycle-counter width
TIMEOUT, 1000000, RUN-cycle limit before forced stop (must be < 2**CW)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled in IDLE only
in_valid  input  1  load byte available
in_data  input  8  load byte
in_ready  output  1  controller accepts load byte this cycle
out_valid  output  1  result byte available
out_data  output  8  result byte
out_ready  input  1  consumer accepts result byte
core_reset  output  1  reset to core; low only in RUN
core_done  input  1  core halt indication (combinational from core)
mem_sel  output  1  1 = controller drives data-memory port, 0 = core drives it
mem_wr_en  output  1  memory write strobe
mem_addr  output  AW  memory address
mem_wdat  output  8  memory write data
mem_rdat  input  8  memory read data, combinational from mem_addr
busy  output  1  high in any state other than IDLE
timed_out  output  1  last run ended by TIMEOUT; held until next start
finished  output  1  one-cycle pulse on FINISH -> IDLE
cycle_count  output  CW  RUN cycles of last/current run

Behaviour:
- Reset:
  - state = IDLE; core_reset = 1; mem_sel = 1.
  - in_ready, out_valid, mem_wr_en, busy, timed_out and finished = 0.
  - cycle_count = 0; ptr = 0.
  - Reset mid-operation aborts the run immediately: no further memory writes, and the output stream is dropped.
- States: IDLE, LOAD, RUN, DRAIN, FINISH.
- IDLE:
  - start = 1 -> clear timed_out, cycle_count and ptr.
  - Next state is LOAD, or RUN if LOAD_LEN = 0.
  - start in any other state is ignored.
- LOAD:
  - in_ready = 1.
  - mem_addr = LOAD_BASE + ptr, with wrap modulo 2**AW.
  - mem_wdat = in_data; mem_wr_en = in_valid (same cycle).
  - Each handshake increments ptr.
  - Handshake with ptr = LOAD_LEN-1 -> RUN, ptr cleared.
  - in_valid low inserts stalls with no write.
- RUN:
  - core_reset = 0; mem_sel = 0; mem_wr_en = 0; in_ready = 0.
  - cycle_count increments every RUN cycle, including the cycle in which core_done is sampled high.
  - core_done = 1 -> DRAIN (or FINISH if DRAIN_LEN = 0).
  - cycle_count reaching TIMEOUT with core_done low -> timed_out = 1, same exit path.
  - If core_done and the timeout coincide, done wins: timed_out stays 0.
  - core_reset returns high in the cycle after exit.
- DRAIN:
  - out_valid = 1; mem_addr = DRAIN_BASE + ptr (wrap).
  - out_data = mem_rdat, combinational, stable while out_ready is low.
  - Each handshake increments ptr.
  - Handshake with ptr = DRAIN_LEN-1 -> FINISH.
- FINISH: finished = 1 for exactly one cycle -> IDLE.
  - cycle_count and timed_out hold until the next start.
- Outside LOAD and DRAIN: mem_addr = 0 and mem_wdat = 0.
- in_ready and out_valid are never both high.

Decomposition:
- Package run_ctrl_pkg: state enum (run_state_e, 3 bits) and default window constants.
- Sub-module addr_walker: a pointer counter with clear, step and last-flag outputs, parameterised by AW and a length. It is instantiated once and shared by LOAD and DRAIN, since the two never overlap.

Test Plan:
- Load then halt:
  - LOAD_LEN = 4; stream 8'h11, 8'h22, 8'h33, 8'h44 with no stalls.
  - Required: writes to addresses 0..3 on consecutive cycles.
  - Core_done model raises on the 5th RUN cycle -> cycle_count = 5 and timed_out = 0.
- Backpressure:
  - in_valid toggles every other cycle, and out_ready is low for 3 cycles mid-drain.
  - Required: no duplicated or skipped addresses, and out_data stays stable while stalled.
- Timeout:
  - TIMEOUT = 10 with core_done held low.
  - Required: exactly 10 RUN cycles, timed_out = 1, and DRAIN still emits DRAIN_LEN bytes.
- Zero-length windows:
  - LOAD_LEN = 0 and DRAIN_LEN = 0.
  - Required: IDLE -> RUN the cycle after start; after done, FINISH with a one-cycle finished pulse, then IDLE.
- Address wrap:
  - DRAIN_BASE = 8'hFE, DRAIN_LEN = 4.
  - Required: the drain reads addresses FE, FF, 00, 01 in that order.
- Reset mid-run:
  - Assert reset during the 3rd LOAD byte.
  - Required: next cycle is IDLE with core_reset = 1, busy = 0 and no mem_wr_en; a start ignored while busy produces no effect.
